// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 raster timing and the colour-bar lookup
//               shared by the VGA timing generator and its axis counters.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package vga_pkg;

    // 640x480@60 with a 25 MHz pixel clock
    localparam int c_h_active = 640;
    localparam int c_h_fp     = 16;
    localparam int c_h_sync   = 96;
    localparam int c_h_bp     = 48;
    localparam int c_v_active = 480;
    localparam int c_v_fp     = 10;
    localparam int c_v_sync   = 2;
    localparam int c_v_bp     = 33;
    localparam int c_cw       = 10;

    // Bar colours, {R,G,B} with 4-bit channels at full scale
    localparam logic [11:0] c_bar_white   = 12'hFFF;
    localparam logic [11:0] c_bar_yellow  = 12'hFF0;
    localparam logic [11:0] c_bar_cyan    = 12'h0FF;
    localparam logic [11:0] c_bar_green   = 12'h0F0;
    localparam logic [11:0] c_bar_magenta = 12'hF0F;
    localparam logic [11:0] c_bar_red     = 12'hF00;
    localparam logic [11:0] c_bar_blue    = 12'h00F;
    localparam logic [11:0] c_bar_black   = 12'h000;

    // Bars are 128 px wide (column bits [9:7]); a 640-wide line shows bars 0..4.
    function automatic logic [11:0] bar_colour(input int x);
        logic [2:0] idx;
        idx = 3'((x >> 7) & 7);
        case (idx)
            3'd0:    return c_bar_white;
            3'd1:    return c_bar_yellow;
            3'd2:    return c_bar_cyan;
            3'd3:    return c_bar_green;
            3'd4:    return c_bar_magenta;
            3'd5:    return c_bar_red;
            3'd6:    return c_bar_blue;
            default: return c_bar_black;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis (horizontal or vertical). Counts 0..MAX on
//               each enable, reports the wrap, the post-strobe count and its
//               active flag, and the sync pin level for the current count.
// Ports       : clk, rst (async, active-high), i_en (advance strobe),
//               o_next (count after this strobe), o_next_active,
//               o_wrap (strobe at MAX), o_sync_lvl (HS/VS level)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter #(
    parameter int CW         = 10,
    parameter int MAX        = 799,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter int ACTIVE     = 640,
    parameter bit POL        = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    output logic [CW-1:0] o_next,
    output logic          o_next_active,
    output logic          o_wrap,
    output logic          o_sync_lvl
);

    logic [CW-1:0] r_count;
    logic          w_at_max;
    logic [CW-1:0] w_inc;
    logic          w_in_sync;

    assign w_at_max = (r_count == CW'(MAX));
    assign w_inc    = w_at_max ? '0 : r_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_inc;
        end
    end

    // Stage-0 outputs are registered from these, so they describe the count
    // that becomes current at this strobe rather than the one being left.
    assign o_next        = i_en ? w_inc : r_count;
    assign o_next_active = (o_next < CW'(ACTIVE));
    assign o_wrap        = i_en & w_at_max;

    assign w_in_sync  = (r_count >= CW'(SYNC_START)) &&
                        (r_count <  CW'(SYNC_START + SYNC_LEN));
    assign o_sync_lvl = w_in_sync ? POL : !POL;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. A clock divider
//               makes the pixel strobe, two axis counters walk the raster,
//               stage 0 requests pixel (x,y,de_req) from the source, stage 1
//               returns blanked RGB aligned with HS/VS one clk later.
// Ports       : clk, rst (async, active-high), pattern_sel (colour bars),
//               rgb_in {R,G,B} for the requested pixel; x, y, de_req,
//               pix_en, line_start, frame_start (stage 0); HS, VS, R, G, B
//               (stage 1)
// Revision    : 1.0 - successor to the fixed 640x480 sync block
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = c_cw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pattern_sel,
    input  logic [11:0]   rgb_in,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          de_req,
    output logic          pix_en,
    output logic          line_start,
    output logic          frame_start,
    output logic          HS,
    output logic          VS,
    output logic [3:0]    R,
    output logic [3:0]    G,
    output logic [3:0]    B
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_dw      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
            c_h_total >= 2**CW || c_v_total >= 2**CW) begin : g_param_check
            $error("vga_timing_gen: illegal timing parameter set");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel strobe
    // ------------------------------------------------------------------
    logic [c_dw-1:0] r_div;
    logic            w_div_last;

    assign w_div_last = (r_div == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Gated by rst so that with CLK_DIV=1 the strobe is still low in reset.
    assign pix_en = w_div_last & ~rst;

    // ------------------------------------------------------------------
    // Axis counters; the vertical axis steps on the horizontal wrap
    // ------------------------------------------------------------------
    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_h_next_active;
    logic          w_v_next_active;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_sync_lvl;
    logic          w_v_sync_lvl;

    vga_axis_counter #(
        .CW        (CW),
        .MAX       (c_h_total - 1),
        .SYNC_START(H_ACTIVE + H_FP),
        .SYNC_LEN  (H_SYNC),
        .ACTIVE    (H_ACTIVE),
        .POL       (HS_POL)
    ) u_h_axis (
        .clk          (clk),
        .rst          (rst),
        .i_en         (pix_en),
        .o_next       (w_h_next),
        .o_next_active(w_h_next_active),
        .o_wrap       (w_h_wrap),
        .o_sync_lvl   (w_h_sync_lvl)
    );

    vga_axis_counter #(
        .CW        (CW),
        .MAX       (c_v_total - 1),
        .SYNC_START(V_ACTIVE + V_FP),
        .SYNC_LEN  (V_SYNC),
        .ACTIVE    (V_ACTIVE),
        .POL       (VS_POL)
    ) u_v_axis (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_h_wrap),
        .o_next       (w_v_next),
        .o_next_active(w_v_next_active),
        .o_wrap       (w_v_wrap),
        .o_sync_lvl   (w_v_sync_lvl)
    );

    // ------------------------------------------------------------------
    // Stage 0: pixel request, held for the whole pixel period
    // ------------------------------------------------------------------
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;
    logic          w_de_next;

    assign w_de_next = w_h_next_active & w_v_next_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            // Wrap pulses only exist in a pix_en clock, so these are one clk wide.
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
            if (pix_en) begin
                r_de <= w_de_next;
                r_x  <= w_de_next ? w_h_next : '0;
                r_y  <= w_de_next ? w_v_next : '0;
            end
        end
    end

    assign de_req      = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

    // ------------------------------------------------------------------
    // Stage 1: pins, updated every clk so pattern_sel/rgb_in are honoured
    // per sample while sync only depends on the counters
    // ------------------------------------------------------------------
    logic        r_hs;
    logic        r_vs;
    logic [11:0] r_rgb;
    logic [11:0] w_src;

    assign w_src = pattern_sel ? bar_colour(int'(r_x)) : rgb_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs  <= !HS_POL;
            r_vs  <= !VS_POL;
            r_rgb <= '0;
        end else begin
            r_hs  <= w_h_sync_lvl;
            r_vs  <= w_v_sync_lvl;
            r_rgb <= r_de ? w_src : 12'h000;
        end
    end

    assign HS = r_hs;
    assign VS = r_vs;
    assign R  = r_rgb[11:8];
    assign G  = r_rgb[7:4];
    assign B  = r_rgb[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Three instances
//               (default 640x480 CLK_DIV=4, tiny CLK_DIV=1 HS_POL=1, small
//               CLK_DIV=3 VS_POL=1) are compared against a clock-count model
//               plus a table of hand-computed probe points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        de;
        logic        pix;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    typedef struct {
        int div;
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int          n;
        bit          pat;
        logic [11:0] rgb;
        logic [9:0]  exp_x;
        logic        exp_de;
        logic        exp_hs;
        logic [11:0] exp_rgb;
    } tv_t;

    cfg_t cfg_a = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t cfg_b = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0};
    cfg_t cfg_c = '{3, 16, 2, 3, 1, 6, 1, 2, 1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_a, rst_b, rst_c;
    logic        pat;
    logic [11:0] rgb;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic       a_de, a_pix, a_ls, a_fs, a_hs, a_vs;
    logic       b_de, b_pix, b_ls, b_fs, b_hs, b_vs;
    logic       c_de, c_pix, c_ls, c_fs, c_hs, c_vs;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .pattern_sel(pat), .rgb_in(rgb),
        .x(a_x), .y(a_y), .de_req(a_de), .pix_en(a_pix),
        .line_start(a_ls), .frame_start(a_fs), .HS(a_hs), .VS(a_vs),
        .R(a_r), .G(a_g), .B(a_b)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b0)
    ) u_b (
        .clk(clk), .rst(rst_b), .pattern_sel(pat), .rgb_in(rgb),
        .x(b_x), .y(b_y), .de_req(b_de), .pix_en(b_pix),
        .line_start(b_ls), .frame_start(b_fs), .HS(b_hs), .VS(b_vs),
        .R(b_r), .G(b_g), .B(b_b)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_c (
        .clk(clk), .rst(rst_c), .pattern_sel(pat), .rgb_in(rgb),
        .x(c_x), .y(c_y), .de_req(c_de), .pix_en(c_pix),
        .line_start(c_ls), .frame_start(c_fs), .HS(c_hs), .VS(c_vs),
        .R(c_r), .G(c_g), .B(c_b)
    );

    function automatic vec_t obs(input int id);
        case (id)
            0:       return {a_x, a_y, a_de, a_pix, a_ls, a_fs, a_hs, a_vs, a_r, a_g, a_b};
            1:       return {b_x, b_y, b_de, b_pix, b_ls, b_fs, b_hs, b_vs, b_r, b_g, b_b};
            default: return {c_x, c_y, c_de, c_pix, c_ls, c_fs, c_hs, c_vs, c_r, c_g, c_b};
        endcase
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("x=%0d y=%0d de=%b pix=%b ls=%b fs=%b hs=%b vs=%b rgb=%h",
                         v.x, v.y, v.de, v.pix, v.ls, v.fs, v.hs, v.vs, v.rgb);
    endfunction

    // Eight 128-px bars: white yellow cyan green magenta red blue black
    function automatic logic [11:0] bar(input int xc);
        case ((xc / 128) % 8)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic vec_t reset_vec(input cfg_t c);
        vec_t e;
        e     = '0;
        e.hs  = !c.hpol;
        e.vs  = !c.vpol;
        return e;
    endfunction

    // Expected outputs after n clock edges since reset release, from the
    // number of pixel strobes completed so far (pixel p = n / CLK_DIV).
    function automatic vec_t model(input cfg_t c, input int n, input bit p,
                                   input logic [11:0] d);
        vec_t e;
        int   ht, vt, pn, p1, h, v, h1, v1, xs, ss;
        bit   de0, de1;
        ht   = c.ha + c.hfp + c.hsw + c.hbp;
        vt   = c.va + c.vfp + c.vsw + c.vbp;
        pn   = n / c.div;
        p1   = (n - 1) / c.div;
        h    = pn % ht;
        v    = (pn / ht) % vt;
        h1   = p1 % ht;
        v1   = (p1 / ht) % vt;
        de0  = (pn > 0) && (h < c.ha) && (v < c.va);
        de1  = (p1 > 0) && (h1 < c.ha) && (v1 < c.va);
        e.x  = de0 ? 10'(h) : 10'd0;
        e.y  = de0 ? 10'(v) : 10'd0;
        e.de = de0;
        e.pix = ((n % c.div) == c.div - 1);
        e.ls = ((n % c.div) == 0) && (h == 0);
        e.fs = e.ls && (v == 0);
        ss   = c.ha + c.hfp;
        e.hs = (h1 >= ss && h1 < ss + c.hsw) ? c.hpol : !c.hpol;
        ss   = c.va + c.vfp;
        e.vs = (v1 >= ss && v1 < ss + c.vsw) ? c.vpol : !c.vpol;
        xs   = de1 ? h1 : 0;
        e.rgb = !de1 ? 12'h000 : (p ? bar(xs) : d);
        return e;
    endfunction

    task automatic check(input string name, input vec_t got, input vec_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got(%s) exp(%s)", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock on a DUT: optionally new random inputs, edge, model compare.
    task automatic step_chk(input int id, input cfg_t c, inout int n, input bit rnd);
        if (rnd) begin
            pat = 1'($urandom);
            rgb = 12'($urandom);
        end
        @(posedge clk);
        n++;
        #1;
        check($sformatf("dut%0d_n%0d", id, n), obs(id), model(c, n, pat, rgb));
    endtask

    tv_t tv[13];
    int  n_a, n_b, n_c;

    initial begin
        // Probe points on the default instance: n = 4*h + 2 shows pixel h of line 0
        tv[0]  = '{6,    1'b1, 12'h000, 10'd1,   1'b1, 1'b1, 12'hFFF};
        tv[1]  = '{510,  1'b1, 12'h000, 10'd127, 1'b1, 1'b1, 12'hFFF};
        tv[2]  = '{514,  1'b1, 12'h000, 10'd128, 1'b1, 1'b1, 12'hFF0};
        tv[3]  = '{1026, 1'b1, 12'h000, 10'd256, 1'b1, 1'b1, 12'h0FF};
        tv[4]  = '{1202, 1'b0, 12'hABC, 10'd300, 1'b1, 1'b1, 12'hABC};
        tv[5]  = '{1206, 1'b0, 12'h123, 10'd301, 1'b1, 1'b1, 12'h123};
        tv[6]  = '{1538, 1'b1, 12'hABC, 10'd384, 1'b1, 1'b1, 12'h0F0};
        tv[7]  = '{2558, 1'b1, 12'hABC, 10'd639, 1'b1, 1'b1, 12'hF0F};
        tv[8]  = '{2562, 1'b1, 12'hABC, 10'd0,   1'b0, 1'b1, 12'h000};
        tv[9]  = '{2622, 1'b0, 12'hABC, 10'd0,   1'b0, 1'b1, 12'h000};
        tv[10] = '{2626, 1'b0, 12'hABC, 10'd0,   1'b0, 1'b0, 12'h000};
        tv[11] = '{3006, 1'b0, 12'hABC, 10'd0,   1'b0, 1'b0, 12'h000};
        tv[12] = '{3202, 1'b0, 12'hABC, 10'd0,   1'b1, 1'b1, 12'hABC};

        pat   = 1'b0;
        rgb   = 12'h000;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", obs(0), reset_vec(cfg_a));
        check("rst_b", obs(1), reset_vec(cfg_b));
        check("rst_c", obs(2), reset_vec(cfg_c));

        // ---------------- default instance: probe table ----------------
        rst_a = 1'b0;
        n_a   = 0;
        for (int i = 0; i < 13; i++) begin
            pat = tv[i].pat;
            rgb = tv[i].rgb;
            while (n_a < tv[i].n) begin
                @(posedge clk);
                n_a++;
                #1;
            end
            check_int($sformatf("tv%0d_x", i), int'(a_x), int'(tv[i].exp_x));
            check_int($sformatf("tv%0d_de", i), int'(a_de), int'(tv[i].exp_de));
            check_int($sformatf("tv%0d_hs", i), int'(a_hs), int'(tv[i].exp_hs));
            check_int($sformatf("tv%0d_rgb", i), int'({a_r, a_g, a_b}), int'(tv[i].exp_rgb));
        end
        // ---------------- default instance: random against model -------
        for (int k = 0; k < 7000; k++) step_chk(0, cfg_a, n_a, 1'b1);
        rst_a = 1'b1;

        // ---------------- tiny instance, CLK_DIV=1 ----------------------
        rst_b = 1'b0;
        n_b   = 0;
        for (int k = 0; k < 490; k++) step_chk(1, cfg_b, n_b, 1'b1);
        begin
            int last_fs, last_rise, hi_run, fs_cnt;
            bit prev_hs;
            last_fs   = -1;
            last_rise = -1;
            hi_run    = 0;
            fs_cnt    = 0;
            prev_hs   = b_hs;
            for (int k = 0; k < 300; k++) begin
                step_chk(1, cfg_b, n_b, 1'b1);
                if (b_fs) begin
                    if (last_fs >= 0) check_int("b_frame_period", n_b - last_fs, 98);
                    last_fs = n_b;
                    fs_cnt++;
                end
                if (b_hs && !prev_hs) begin
                    if (last_rise >= 0) check_int("b_hs_period", n_b - last_rise, 14);
                    last_rise = n_b;
                    hi_run    = 0;
                end
                if (b_hs) hi_run++;
                if (!b_hs && prev_hs && last_rise >= 0) check_int("b_hs_width", hi_run, 2);
                prev_hs = b_hs;
            end
            check_int("b_frame_starts_seen", fs_cnt, 3);
        end
        rst_b = 1'b1;

        // ---------------- small instance, mid-frame async reset ---------
        rst_c = 1'b0;
        n_c   = 0;
        for (int k = 0; k < 800; k++) step_chk(2, cfg_c, n_c, 1'b1);
        #2;
        rst_c = 1'b1;
        #1;
        check("c_async_rst_now", obs(2), reset_vec(cfg_c));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("c_rst_hold%0d", k), obs(2), reset_vec(cfg_c));
        end
        rst_c = 1'b0;
        n_c   = 0;
        for (int k = 0; k < 1400; k++) step_chk(2, cfg_c, n_c, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
